// File: rtl/instr_fetch_decode_if.sv
// Fetch/decode bus between the PE controller, instruction memory and
// instr_fetch_decode. "slave" is the fetch/decode block's view; "master" is
// the controller + instruction-memory side.
interface instr_fetch_decode_if;
  logic        IRenable;
  logic [31:0] PCin;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_data;
  logic        imem_ack;
  logic [6:0]  op;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [11:0] imm12;
  logic [19:0] immhi;
  logic        decodeComplete;
  logic        fetch_err;
  logic        illegal;

  modport master (
    output IRenable, PCin, imem_data, imem_ack,
    input  imem_read, imem_address, op, rd, funct3, rs1, rs2, funct7,
           imm12, immhi, decodeComplete, fetch_err, illegal
  );

  modport slave (
    input  IRenable, PCin, imem_data, imem_ack,
    output imem_read, imem_address, op, rd, funct3, rs1, rs2, funct7,
           imm12, immhi, decodeComplete, fetch_err, illegal
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: RISC-V PE fetch-and-decode front end.
// Reads one instruction word at the controller's PC, latches it into IR,
// splits it into registered fields and raises decodeComplete.
// Optional macro IFD_ILLEGAL_CHECK_EN enables the illegal-encoding flag;
// without it, illegal is tied low.
module instr_fetch_decode #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_decode_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DECODE, DONE} state_t;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [11:0] imm12;
    logic [19:0] immhi;
  } fields_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        read_q, read_d;
  logic        err_q, err_d;
  logic        dc_q, dc_d;
  fields_t     fld_q, fld_d;
  fields_t     dec;

  // The two low PC bits never reach memory: fetches are word-aligned.
  logic [1:0] unused_pc_lsbs;
  assign unused_pc_lsbs = bus.PCin[1:0];

  // Split IR into fields and pick the immediates for its format.
  always_comb begin
    dec        = '0;
    dec.op     = ir_q[6:0];
    dec.rd     = ir_q[11:7];
    dec.funct3 = ir_q[14:12];
    dec.rs1    = ir_q[19:15];
    dec.rs2    = ir_q[24:20];
    dec.funct7 = ir_q[31:25];
    case (ir_q[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: dec.imm12 = ir_q[31:20];
      OP_STORE:          dec.imm12 = {ir_q[31:25], ir_q[11:7]};
      OP_BRANCH:         dec.imm12 = {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8]};
      OP_LUI, OP_AUIPC:  dec.immhi = ir_q[31:12];
      OP_JAL:            dec.immhi = {ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21]};
      default: ;
    endcase
  end

  // Next-state and datapath updates of the fetch/decode sequence.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    read_d  = read_q;
    err_d   = err_q;
    dc_d    = dc_q;
    fld_d   = fld_q;
    case (state_q)
      IDLE: begin
        if (bus.IRenable) begin
          addr_d  = {bus.PCin[31:2], 2'b00};
          read_d  = 1'b1;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // An ack on the timeout cycle takes priority over the abort.
        if (bus.imem_ack) begin
          ir_d    = bus.imem_data;
          read_d  = 1'b0;
          state_d = DECODE;
        end else if (cnt_q == CNT_LAST) begin
          ir_d    = NOP_WORD;
          err_d   = 1'b1;
          read_d  = 1'b0;
          state_d = DECODE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DECODE: begin
        fld_d   = dec;
        dc_d    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!bus.IRenable) begin
          dc_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: IR, timeout counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_q   <= '0;
      cnt_q  <= '0;
      addr_q <= '0;
      read_q <= 1'b0;
      err_q  <= 1'b0;
      dc_q   <= 1'b0;
      fld_q  <= '0;
    end else begin
      ir_q   <= ir_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      read_q <= read_d;
      err_q  <= err_d;
      dc_q   <= dc_d;
      fld_q  <= fld_d;
    end
  end

`ifdef IFD_ILLEGAL_CHECK_EN
  logic illegal_q, illegal_d, illegal_dec;

  // Flag encodings outside the supported RV32I opcode/funct7 set.
  always_comb begin
    illegal_dec = 1'b0;
    if (ir_q[1:0] != 2'b11) illegal_dec = 1'b1;
    case (ir_q[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
      OP_IMM, OP_FENCE, OP_SYSTEM: ;
      OP_OP: begin
        if (ir_q[31:25] != 7'b0000000 && ir_q[31:25] != 7'b0100000)
          illegal_dec = 1'b1;
      end
      default: illegal_dec = 1'b1;
    endcase
    illegal_d = (state_q == DECODE) ? illegal_dec : illegal_q;
  end

  // Illegal flag is captured in DECODE and held until the next decode.
  always_ff @(posedge clk) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.imem_read      = read_q;
  assign bus.imem_address   = addr_q;
  assign bus.op             = fld_q.op;
  assign bus.rd             = fld_q.rd;
  assign bus.funct3         = fld_q.funct3;
  assign bus.rs1            = fld_q.rs1;
  assign bus.rs2            = fld_q.rs2;
  assign bus.funct7         = fld_q.funct7;
  assign bus.imm12          = fld_q.imm12;
  assign bus.immhi          = fld_q.immhi;
  assign bus.decodeComplete = dc_q;
  assign bus.fetch_err      = err_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode (built with TIMEOUT_CYCLES=4).
// Expected decode results are queued when a fetch is requested and compared
// when decodeComplete rises.
module tb_instr_fetch_decode;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_decode_if bus();

  instr_fetch_decode #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [11:0] imm12;
    logic [19:0] immhi;
    logic        err;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] w, input logic err);
    exp_t e;
    logic [12:0] boff;
    logic [20:0] joff;
    e.addr   = pc & 32'hFFFF_FFFC;
    e.op     = w[6:0];
    e.rd     = w[11:7];
    e.funct3 = w[14:12];
    e.rs1    = w[19:15];
    e.rs2    = w[24:20];
    e.funct7 = w[31:25];
    e.imm12  = 12'h000;
    e.immhi  = 20'h00000;
    e.err    = err;
    boff = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    joff = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: e.imm12 = w[31:20];
      7'h23: e.imm12 = {w[31:25], w[11:7]};
      7'h63: e.imm12 = boff[12:1];
      7'h37, 7'h17: e.immhi = w[31:12];
      7'h6F: e.immhi = joff[20:1];
      default: ;
    endcase
`ifdef IFD_ILLEGAL_CHECK_EN
    e.ill = (w[1:0] != 2'b11) ||
            !(w[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                             7'h13, 7'h33, 7'h0F, 7'h73}) ||
            (w[6:0] == 7'h33 && !(w[31:25] inside {7'h00, 7'h20}));
`else
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  // Scoreboard: compare the queued expectation on each decodeComplete rise.
  logic dc_prev = 1'b0;
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (bus.decodeComplete === 1'b1 && dc_prev !== 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: decodeComplete rose with no fetch outstanding");
      end else begin
        mon_e = sb_q.pop_front();
        if ({bus.imem_address, bus.op, bus.rd, bus.funct3, bus.rs1, bus.rs2, bus.funct7,
             bus.imm12, bus.immhi, bus.fetch_err, bus.illegal} !==
            {mon_e.addr, mon_e.op, mon_e.rd, mon_e.funct3, mon_e.rs1, mon_e.rs2, mon_e.funct7,
             mon_e.imm12, mon_e.immhi, mon_e.err, mon_e.ill}) begin
          failures++;
          $display("FAIL sb_decode: got addr=%h op=%h rd=%h f3=%h rs1=%h rs2=%h f7=%h imm12=%h immhi=%h err=%b ill=%b expected addr=%h op=%h rd=%h f3=%h rs1=%h rs2=%h f7=%h imm12=%h immhi=%h err=%b ill=%b",
                   bus.imem_address, bus.op, bus.rd, bus.funct3, bus.rs1, bus.rs2, bus.funct7,
                   bus.imm12, bus.immhi, bus.fetch_err, bus.illegal,
                   mon_e.addr, mon_e.op, mon_e.rd, mon_e.funct3, mon_e.rs1, mon_e.rs2, mon_e.funct7,
                   mon_e.imm12, mon_e.immhi, mon_e.err, mon_e.ill);
        end
      end
    end
    dc_prev = bus.decodeComplete;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request a fetch, ack it m cycles after the request edge, then wait
  // (bounded) for decodeComplete. lat counts edges from the request edge.
  task automatic drive_fetch(input logic [31:0] pc, input logic [31:0] data, input int m,
                             input bit drop, output int lat, output int rd_hi,
                             output logic rd_after);
    sb_q.push_back(model(pc, data, 1'b0));
    bus.IRenable = 1'b1;
    bus.PCin     = pc;
    lat   = 0;
    rd_hi = 0;
    tick(); lat++;
    if (drop) bus.IRenable = 1'b0;
    for (int i = 1; i < m; i++) begin
      if (bus.imem_read === 1'b1) rd_hi++;
      tick(); lat++;
    end
    if (bus.imem_read === 1'b1) rd_hi++;
    bus.imem_ack  = 1'b1;
    bus.imem_data = data;
    tick(); lat++;
    bus.imem_ack  = 1'b0;
    bus.imem_data = $urandom;
    rd_after = bus.imem_read;
    for (int i = 0; i < 10 && bus.decodeComplete !== 1'b1; i++) begin
      tick(); lat++;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.IRenable  = 1'b0;
    bus.PCin      = 32'hDEAD_BEEF;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 32'h0;
    tick(); tick();
    checks++;
    if ({bus.imem_read, bus.imem_address, bus.op, bus.rd, bus.funct3, bus.rs1, bus.rs2,
         bus.funct7, bus.imm12, bus.immhi, bus.decodeComplete, bus.fetch_err, bus.illegal} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got addr=%h read=%b op=%h dc=%b err=%b, expected all zero",
               bus.imem_address, bus.imem_read, bus.op, bus.decodeComplete, bus.fetch_err);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    int lat, rd_hi; logic rd_after;
    drive_fetch(32'h0000_0001, 32'h0061_0113, 2, 1'b0, lat, rd_hi, rd_after);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL addi_latency: got %0d edges expected 4", lat); end
    checks++;
    if (rd_hi !== 2 || rd_after !== 1'b0) begin
      failures++; $display("FAIL addi_read_window: got high=%0d after=%b expected high=2 after=0", rd_hi, rd_after);
    end
    checks++;
    if ({bus.imem_address, bus.op, bus.rd, bus.rs1, bus.funct3, bus.imm12} !==
        {32'h0, 7'b0010011, 5'd2, 5'd2, 3'd0, 12'h006}) begin
      failures++;
      $display("FAIL addi_fields: got addr=%h op=%b rd=%0d rs1=%0d f3=%0d imm12=%h expected addr=0 op=0010011 rd=2 rs1=2 f3=0 imm12=006",
               bus.imem_address, bus.op, bus.rd, bus.rs1, bus.funct3, bus.imm12);
    end
    bus.IRenable = 1'b0;
    tick();
    checks++;
    if (bus.decodeComplete !== 1'b0) begin failures++; $display("FAIL addi_release: got dc=%b expected 0", bus.decodeComplete); end
  endtask

  task automatic test_store_min_latency();
    int lat, rd_hi; logic rd_after;
    drive_fetch(32'h0000_0102, 32'h0050_A423, 1, 1'b0, lat, rd_hi, rd_after);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL sw_min_latency: got %0d edges expected 3", lat); end
    checks++;
    if ({bus.imem_address, bus.op, bus.rs1, bus.rs2, bus.funct3, bus.imm12, bus.immhi} !==
        {32'h100, 7'b0100011, 5'd1, 5'd5, 3'b010, 12'h008, 20'h0}) begin
      failures++;
      $display("FAIL sw_fields: got addr=%h op=%b rs1=%0d rs2=%0d f3=%b imm12=%h immhi=%h expected addr=100 op=0100011 rs1=1 rs2=5 f3=010 imm12=008 immhi=0",
               bus.imem_address, bus.op, bus.rs1, bus.rs2, bus.funct3, bus.imm12, bus.immhi);
    end
    bus.IRenable = 1'b0;
    tick();
  endtask

  task automatic test_branch_jump();
    int lat, rd_hi; logic rd_after;
    drive_fetch(32'h0000_0200, 32'hFE00_0EE3, 3, 1'b0, lat, rd_hi, rd_after);
    checks++;
    if (bus.imm12 !== 12'hFFE || bus.immhi !== 20'h0) begin
      failures++; $display("FAIL beq_imm: got imm12=%h immhi=%h expected FFE 00000", bus.imm12, bus.immhi);
    end
    bus.IRenable = 1'b0;
    tick();
    drive_fetch(32'h0000_0204, 32'h0010_00EF, 2, 1'b0, lat, rd_hi, rd_after);
    checks++;
    if (bus.rd !== 5'd1 || bus.immhi !== 20'h00400 || bus.imm12 !== 12'h000) begin
      failures++; $display("FAIL jal_imm: got rd=%0d immhi=%h imm12=%h expected 1 00400 000", bus.rd, bus.immhi, bus.imm12);
    end
    bus.IRenable = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    sb_q.push_back(model(32'h0000_2006, 32'h0000_0013, 1'b1));
    bus.IRenable = 1'b1;
    bus.PCin     = 32'h0000_2006;
    tick();
    for (int i = 0; i < 20; i++) begin
      tick(); n++;
      if (bus.imem_read !== 1'b1) break;
    end
    checks++;
    if (n !== 4 || bus.fetch_err !== 1'b1) begin
      failures++; $display("FAIL timeout_abort: got read_cycles=%0d err=%b expected 4 1", n, bus.fetch_err);
    end
    tick();
    checks++;
    if (bus.decodeComplete !== 1'b1 || bus.op !== 7'b0010011 || bus.imm12 !== 12'h0) begin
      failures++; $display("FAIL timeout_nop: got dc=%b op=%b imm12=%h expected 1 0010011 000",
                           bus.decodeComplete, bus.op, bus.imm12);
    end
    bus.IRenable = 1'b0;
    tick();
  endtask

  task automatic test_ack_at_limit();
    int lat, rd_hi; logic rd_after;
    drive_fetch(32'h0000_3000, 32'h1234_50B7, 4, 1'b0, lat, rd_hi, rd_after);
    checks++;
    if (lat !== 6 || bus.fetch_err !== 1'b0 || bus.immhi !== 20'h12345) begin
      failures++; $display("FAIL ack_at_limit: got lat=%0d err=%b immhi=%h expected 6 0 12345", lat, bus.fetch_err, bus.immhi);
    end
    bus.IRenable = 1'b0;
    tick();
  endtask

  task automatic test_ack_outside_fetch();
    bus.imem_ack  = 1'b1;
    bus.imem_data = 32'h0000_0033;
    tick();
    bus.imem_ack  = 1'b0;
    tick(); tick();
    checks++;
    if (bus.imem_read !== 1'b0 || bus.decodeComplete !== 1'b0 || bus.op !== 7'b0110111) begin
      failures++; $display("FAIL stray_ack: got read=%b dc=%b op=%b expected 0 0 0110111",
                           bus.imem_read, bus.decodeComplete, bus.op);
    end
  endtask

  task automatic test_early_drop();
    int lat, rd_hi; logic rd_after;
    drive_fetch(32'h0000_4000, 32'h0031_0193, 2, 1'b1, lat, rd_hi, rd_after);
    checks++;
    if (lat !== 4 || bus.decodeComplete !== 1'b1) begin
      failures++; $display("FAIL drop_complete: got lat=%0d dc=%b expected 4 1", lat, bus.decodeComplete);
    end
    tick();
    checks++;
    if (bus.decodeComplete !== 1'b0) begin failures++; $display("FAIL drop_pulse: got dc=%b expected 0", bus.decodeComplete); end
    tick();
    checks++;
    if (bus.imem_read !== 1'b0 || bus.decodeComplete !== 1'b0) begin
      failures++; $display("FAIL drop_idle: got read=%b dc=%b expected 0 0", bus.imem_read, bus.decodeComplete);
    end
  endtask

  task automatic test_back_to_back();
    int lat, rd_hi; logic rd_after;
    drive_fetch(32'h0000_5000, 32'h0020_8233, 1, 1'b0, lat, rd_hi, rd_after);
    tick(); tick();
    checks++;
    if (bus.decodeComplete !== 1'b1 || bus.imem_read !== 1'b0) begin
      failures++; $display("FAIL hold_done: got dc=%b read=%b expected 1 0", bus.decodeComplete, bus.imem_read);
    end
    bus.IRenable = 1'b0;
    tick();
    drive_fetch(32'h0000_5004, 32'hFFF0_0293, 1, 1'b0, lat, rd_hi, rd_after);
    checks++;
    if (lat !== 3 || bus.imm12 !== 12'hFFF || bus.rd !== 5'd5) begin
      failures++; $display("FAIL b2b_second: got lat=%0d imm12=%h rd=%0d expected 3 FFF 5", lat, bus.imm12, bus.rd);
    end
    bus.IRenable = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_fetch();
    bus.IRenable = 1'b1;
    bus.PCin     = 32'h0000_6000;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.imem_read, bus.imem_address, bus.op, bus.rd, bus.funct3, bus.rs1, bus.rs2,
         bus.funct7, bus.imm12, bus.immhi, bus.decodeComplete, bus.fetch_err, bus.illegal} !== '0) begin
      failures++;
      $display("FAIL reset_mid_fetch: got read=%b addr=%h op=%h dc=%b expected all zero",
               bus.imem_read, bus.imem_address, bus.op, bus.decodeComplete);
    end
    rst_n = 1'b1;
    bus.IRenable = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    int lat, rd_hi; logic rd_after;
    logic [31:0] words [3] = '{32'h0000_0000, 32'h4000_0033, 32'h2000_0033};
`ifdef IFD_ILLEGAL_CHECK_EN
    logic exp_ill [3] = '{1'b1, 1'b0, 1'b1};
`else
    logic exp_ill [3] = '{1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 3; i++) begin
      drive_fetch(32'h0000_7000 + 32'(i * 4), words[i], 2, 1'b0, lat, rd_hi, rd_after);
      checks++;
      if (bus.illegal !== exp_ill[i]) begin
        failures++; $display("FAIL illegal_%0d: word=%h got %b expected %b", i, words[i], bus.illegal, exp_ill[i]);
      end
      bus.IRenable = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_store_min_latency();
    test_branch_jump();
    test_timeout();
    test_ack_at_limit();
    test_ack_outside_fetch();
    test_early_drop();
    test_back_to_back();
    test_reset_mid_fetch();
    test_illegal();
    tick();
    checks++;
    if (sb_q.size() != 0) begin
      failures++; $display("FAIL sb_drain: got %0d outstanding expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Fetch-and-decode front end of the RISC-V PE. On request from the PE controller it reads one 32-bit instruction word from instruction memory at the controller-supplied PC and latches it into an internal instruction register (IR). It splits the word into the `op`/`funct3`/`funct7`/`rs1`/`rs2`/`rd`/`imm12`/`immhi` fields the controller consumes, then raises `decodeComplete`. It sits directly upstream of the controller: its `IRenable` input is driven by the controller's `IRenable`, and its `PCin` input by the controller's `PCout`.

## Interface

Clocking and reset: one clock `clk`; reset `rst_n` is synchronous, active-low.

Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of FETCH cycles spent waiting for `imem_ack` before aborting; range 1..255.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  synchronous active-low reset
- `IRenable`  in  1  fetch request from the controller; level-held
- `PCin`  in  32  fetch address from the controller
- `imem_read`  out  1  instruction-memory read strobe
- `imem_address`  out  32  word-aligned fetch address
- `imem_data`  in  32  read data; valid in the cycle `imem_ack`=1
- `imem_ack`  in  1  read acknowledge; a one-cycle pulse
- `op`  out  7  `IR[6:0]`
- `rd`  out  5  `IR[11:7]`
- `funct3`  out  3  `IR[14:12]`
- `rs1`  out  5  `IR[19:15]`
- `rs2`  out  5  `IR[24:20]`
- `funct7`  out  7  `IR[31:25]`
- `imm12`  out  12  format-selected 12-bit immediate
- `immhi`  out  20  format-selected 20-bit immediate
- `decodeComplete`  out  1  decoded fields valid and stable
- `fetch_err`  out  1  fetch timed out
- `illegal`  out  1  illegal encoding (configurable)

## Operation

State machine states: IDLE, FETCH, DECODE, DONE.

- **IDLE:** when `IRenable`=1:
  - register `imem_address` = {`PCin[31:2]`, 2'b00}; `PCin[1:0]` is ignored.
  - set `imem_read`=1, clear the timeout counter, clear `fetch_err`, go to FETCH.
- **FETCH:** `imem_read` stays 1; the counter increments each cycle.
  - On `imem_ack`=1: IR ← `imem_data`; `imem_read`=0; go to DECODE.
  - If the counter reaches `TIMEOUT_CYCLES` with no ack: IR ← 0x00000013 (NOP); `fetch_err`=1; `imem_read`=0; go to DECODE.
- **DECODE:** register all field outputs from IR, then go to DONE.
- **DONE:** `decodeComplete`=1 and all fields held stable. When `IRenable`=0 is sampled, clear `decodeComplete` and go to IDLE.

Immediate selection by `op`:
- I-type (0000011, 0010011, 1100111, 1110011): `imm12`=`IR[31:20]`
- S-type (0100011): `imm12`={`IR[31:25]`,`IR[11:7]`}
- B-type (1100011): `imm12`={`IR[31]`,`IR[7]`,`IR[30:25]`,`IR[11:8]`}, i.e. offset>>1
- U-type (0110111, 0010111): `immhi`=`IR[31:12]`
- J-type (1101111): `immhi`={`IR[31]`,`IR[19:12]`,`IR[20]`,`IR[30:21]`}, i.e. offset>>1
- Any immediate not defined for the format is driven to 0.

Boundary conditions:
- `IRenable` dropping during FETCH: the memory read is not aborted. The block completes through DECODE into DONE, asserts `decodeComplete` for exactly one cycle, then returns to IDLE.
- `imem_ack` outside FETCH is ignored.
- `imem_ack` arriving in the same cycle the counter hits the limit: the ack wins and `fetch_err` stays 0.
- `rst_n`=0 in any state: next edge forces IDLE and clears IR, the counter and all outputs.

## Timing

- Reset value of every output is 0, including `imem_address` and all fields.
- All outputs are registered.
- Request sampled at edge k; ack sampled at edge k+m (m≥1); `decodeComplete` rises after edge k+m+1.
- Minimum latency from request to `decodeComplete` is 3 edges.
- `imem_read` is high from edge k to edge k+m.
- Back-to-back fetches: after `IRenable` falls, at least one IDLE cycle occurs before the next request is accepted.

## Configuration

Macro `IFD_ILLEGAL_CHECK_EN`.

- **Defined:** in DECODE, `illegal` is registered to 1 if any of the following holds; `illegal` is held in DONE.
  - `IR[1:0]`≠11
  - `op` is not one of {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011}
  - `op`=0110011 and `funct7` is not in {0000000, 0100000}
- **Undefined:** `illegal` is tied to 0 and no checking logic is synthesized.

## Test plan

- **addi:** `PCin`=0x00000001, `IRenable`=1, `imem_data`=0x00610113, ack after 2 cycles → `imem_address`=0x0; `op`=0010011, `rd`=2, `rs1`=2, `funct3`=0, `imm12`=0x006; `decodeComplete` 4 edges after the request.
- **sw:** `imem_data`=0x0050A423 → `op`=0100011, `rs1`=1, `rs2`=5, `funct3`=010, `imm12`=0x008.
- **beq:** `imem_data`=0xFE000EE3 → `imm12`=0xFFE. **jal:** `imem_data`=0x001000EF → `rd`=1, `immhi`=0x00400.
- **Timeout:** `TIMEOUT_CYCLES`=4, no ack → `imem_read` falls after 4 FETCH cycles; `fetch_err`=1; fields decode NOP (`op`=0010011, `imm12`=0).
- **Early drop:** `IRenable` drops during FETCH, then ack arrives → `decodeComplete` is a single-cycle pulse, then IDLE. **Reset mid-FETCH:** `imem_read`=0 and all outputs 0 on the next edge.
- **Illegal:** with `IFD_ILLEGAL_CHECK_EN`, `imem_data`=0x00000000 → `illegal`=1; 0x40000033 → `illegal`=0; 0x20000033 → `illegal`=1.
